// File: rtl/seq_sub_pkg.sv
// Shared types and sizing helpers for the sequential carry-lookahead subtractor.
// Operands are consumed three bits per clock, so counter sizing derives from WIDTH/SLICE.
package seq_sub_pkg;

  localparam int SLICE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_slices(input int width);
    return width / SLICE;
  endfunction

  // A single-slice build still needs a 1-bit counter register.
  function automatic int cnt_width(input int width);
    return (num_slices(width) > 1) ? $clog2(num_slices(width)) : 1;
  endfunction

endpackage

// File: rtl/sub_cla_slice3.sv
// Combinational 3-bit carry-lookahead slice: sum, carry out and group propagate/generate.
// Zero latency; no flow control.
module sub_cla_slice3 (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  input  logic       cin_i,
  output logic [2:0] sum_o,
  output logic       cout_o,
  output logic       p_o,
  output logic       g_o
);

  logic [2:0] p;
  logic [2:0] g;
  logic [3:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);

  assign sum_o  = p ^ c[2:0];
  assign cout_o = c[3];
  assign p_o    = &p;
  assign g_o    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);

endmodule

// File: rtl/seq_cla_subtractor.sv
// D = A - B - bin as A + ~B + ~bin, one 3-bit CLA slice per clock; out_valid WIDTH/3 edges after accept.
// Holds the result until out_ready; no new accept while busy. SEQ_SUB_OVERFLOW_EN adds the signed ovf output.
module seq_cla_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             bout
`ifdef SEQ_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NS = num_slices(WIDTH);
  localparam int CW = cnt_width(WIDTH);

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_width_chk
    $error("seq_cla_subtractor: WIDTH must be a positive multiple of 3");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

  logic [2:0] sl_sum;
  logic       sl_cout, sl_p, sl_g;

  sub_cla_slice3 u_slice (
    .a_i   (a_q[cnt_q*SLICE +: SLICE]),
    .b_i   (nb_q[cnt_q*SLICE +: SLICE]),
    .cin_i (c_q),
    .sum_o (sl_sum),
    .cout_o(sl_cout),
    .p_o   (sl_p),
    .g_o   (sl_g)
  );

`ifdef SEQ_SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      nb_q    <= '0;
      c_q     <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SEQ_SUB_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      c_q     <= c_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SEQ_SUB_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    nb_d    = nb_q;
    c_d     = c_q;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef SEQ_SUB_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          nb_d    = ~B;
          c_d     = ~bin;
          cnt_d   = '0;
          d_d     = '0;
          bout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_d[cnt_q*SLICE +: SLICE] = sl_sum;
        c_d   = sl_cout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NS - 1)) begin
          // Final borrow taken from the group lookahead terms of the top slice.
          bout_d  = ~(sl_g | (sl_p & c_q));
          cnt_d   = '0;
          state_d = DONE;
`ifdef SEQ_SUB_OVERFLOW_EN
          // nb_q holds ~B, so equal MSBs here mean A and B differ in sign.
          ovf_d = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sl_sum[SLICE-1] != a_q[WIDTH-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign bout      = bout_q;
`ifdef SEQ_SUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule
